// File: rtl/i2s_tdm_tx.sv
// Serial audio transmitter for I2S, left-justified, right-justified and DSP/TDM framing,
// fed through a one-frame holding buffer with underrun repeat of the previous frame.
module i2s_tdm_tx #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 16,
    parameter int PRESC_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [PRESC_W-1:0]           prescaler,
    input  logic [1:0]                   mode,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    output logic                         sclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic                         frame_start,
    output logic                         underrun
);
    localparam int FRAME_W    = CHANNELS * SAMPLE_W;
    localparam int FRAME_BITS = CHANNELS * SLOT_W;
    localparam int SLOT_CW    = $clog2(CHANNELS);
    localparam int POS_W      = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [SLOT_CW-1:0] LAST_SLOT = SLOT_CW'(CHANNELS - 1);
    localparam logic [SLOT_CW-1:0] HALF_SLOT = SLOT_CW'(CHANNELS / 2);
    localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(SLOT_W - 1);

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_RJ  = 2'd2;
    localparam logic [1:0] MODE_DSP = 2'd3;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [FRAME_W-1:0]    buf_data;
    logic                  buf_full;
    logic [FRAME_W-1:0]    last_data;
    logic [FRAME_BITS-1:0] shift_data;
    logic [1:0]            mode_q;
    logic [PRESC_W-1:0]    presc_q;
    logic [PRESC_W-1:0]    half_cnt;
    logic [SLOT_CW-1:0]    slot_cnt;
    logic [POS_W-1:0]      pos_cnt;

    logic                  half_done;
    logic                  frame_end;
    logic                  start_frame;
    logic                  stop_frame;
    logic [SLOT_CW-1:0]    next_slot;
    logic [POS_W-1:0]      next_pos;
    logic [FRAME_W-1:0]    src_data;
    logic [SLOT_W-1:0]     slot_vec;
    logic [FRAME_BITS-1:0] frame_vec;

    assign s_ready = ~buf_full;

    always_comb begin
        half_done   = (half_cnt == presc_q);
        frame_end   = (state == RUN) && sclk && half_done &&
                      (slot_cnt == LAST_SLOT) && (pos_cnt == LAST_POS);
        start_frame = enable && ((state == IDLE) || frame_end);
        stop_frame  = !enable && frame_end;
        if (pos_cnt == LAST_POS) begin
            next_pos  = '0;
            next_slot = slot_cnt + SLOT_CW'(1);
        end else begin
            next_pos  = pos_cnt + POS_W'(1);
            next_slot = slot_cnt;
        end
    end

    // Lay the next frame out as one serial stream, MSB first, using the mode about to be latched.
    always_comb begin
        src_data  = buf_full ? buf_data : last_data;
        slot_vec  = '0;
        frame_vec = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            slot_vec = '0;
            slot_vec[SAMPLE_W-1:0] = src_data[ch*SAMPLE_W +: SAMPLE_W];
            if (mode != MODE_RJ) begin
                slot_vec = slot_vec << (SLOT_W - SAMPLE_W);
            end
            frame_vec[FRAME_BITS-1-ch*SLOT_W -: SLOT_W] = slot_vec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (s_valid && !buf_full) begin
            buf_data <= s_data;
            buf_full <= 1'b1;
        end else if (start_frame && buf_full) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sclk        <= 1'b0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            last_data   <= '0;
            shift_data  <= '0;
            mode_q      <= '0;
            presc_q     <= '0;
            half_cnt    <= '0;
            slot_cnt    <= '0;
            pos_cnt     <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (start_frame) begin
                state       <= RUN;
                mode_q      <= mode;
                presc_q     <= prescaler;
                half_cnt    <= '0;
                slot_cnt    <= '0;
                pos_cnt     <= '0;
                sclk        <= 1'b0;
                frame_start <= 1'b1;
                shift_data  <= frame_vec;
                lrclk       <= (mode == MODE_DSP);
                // After a full frame the shifter's MSB holds the old frame's final bit.
                if (mode == MODE_I2S) begin
                    sdata <= (state == RUN) ? shift_data[FRAME_BITS-1] : 1'b0;
                end else begin
                    sdata <= frame_vec[FRAME_BITS-1];
                end
                if (buf_full) begin
                    last_data <= buf_data;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (stop_frame) begin
                state    <= IDLE;
                sclk     <= 1'b0;
                lrclk    <= 1'b0;
                sdata    <= 1'b0;
                half_cnt <= '0;
                slot_cnt <= '0;
                pos_cnt  <= '0;
            end else if (state == RUN) begin
                if (!half_done) begin
                    half_cnt <= half_cnt + PRESC_W'(1);
                end else begin
                    half_cnt <= '0;
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk       <= 1'b0;
                        slot_cnt   <= next_slot;
                        pos_cnt    <= next_pos;
                        shift_data <= shift_data << 1;
                        sdata      <= (mode_q == MODE_I2S) ? shift_data[FRAME_BITS-1]
                                                           : shift_data[FRAME_BITS-2];
                        lrclk      <= (mode_q == MODE_DSP) ? 1'b0 : (next_slot >= HALF_SLOT);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Drives three transmitter configurations with shared stimulus and checks every cycle
// against a frame-level model computed from bit position, slot and mode.
module tb_i2s_tdm_tx;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  prescaler;
    logic [1:0]  mode;
    logic        s_valid;
    logic [63:0] s_data;

    logic [5:0]  act_v [3];
    logic [5:0]  exp_v [3];
    int          n_vec;
    int          n_err;
    int          cyc;

    bit          running [3];
    bit          bfull   [3];
    bit          prevb   [3];
    int          t       [3];
    int          p       [3];
    int          m       [3];
    logic [63:0] frame   [3];
    logic [63:0] last    [3];
    logic [63:0] bdata   [3];

    always #5 clk = ~clk;

    function automatic int cfgCh(input int g);
        return (g == 2) ? 4 : 2;
    endfunction

    function automatic int cfgSl(input int g);
        return (g == 1) ? 24 : 16;
    endfunction

    // Stream bit k of a frame of 16-bit samples; layout 0 is the left-justified stream delayed one bit.
    function automatic logic expBit(input logic [63:0] fr, input int k, input int lay,
                                    input int sl, input logic prev);
        int kk, slot, pos, pad;
        kk = k;
        if (lay == 0) begin
            if (k == 0) return prev;
            kk = k - 1;
        end
        slot = kk / sl;
        pos  = kk % sl;
        pad  = sl - 16;
        if (lay == 2) begin
            if (pos < pad) return 1'b0;
            return fr[slot*16 + 15 - (pos - pad)];
        end
        if (pos >= 16) return 1'b0;
        return fr[slot*16 + 15 - pos];
    endfunction

    function automatic logic expLr(input int k, input int md, input int ch, input int sl);
        if (md == 3) return (k == 0);
        return ((k / sl) >= (ch / 2));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int CH = (g == 2) ? 4 : 2;
        localparam int SL = (g == 1) ? 24 : 16;
        logic sclk_w, lrclk_w, sdata_w, fs_w, ur_w, ready_w;

        i2s_tdm_tx #(.CHANNELS(CH), .SAMPLE_W(16), .SLOT_W(SL), .PRESC_W(8)) dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .enable      (enable),
            .prescaler   (prescaler),
            .mode        (mode),
            .s_valid     (s_valid),
            .s_ready     (ready_w),
            .s_data      (s_data[CH*16-1:0]),
            .sclk        (sclk_w),
            .lrclk       (lrclk_w),
            .sdata       (sdata_w),
            .frame_start (fs_w),
            .underrun    (ur_w)
        );

        assign act_v[g] = {sclk_w, lrclk_w, sdata_w, fs_w, ur_w, ready_w};
    end

    task automatic modelReset();
        for (int g = 0; g < 3; g++) begin
            running[g] = 1'b0;
            bfull[g]   = 1'b0;
            prevb[g]   = 1'b0;
            t[g]       = 0;
            p[g]       = 0;
            m[g]       = 0;
            frame[g]   = '0;
            last[g]    = '0;
            bdata[g]   = '0;
            exp_v[g]   = 6'b000001;
        end
    endtask

    task automatic modelStep();
        bit start, load, fs, ur;
        int sl, nb, per, k, w;
        if (!reset_n) begin
            modelReset();
            return;
        end
        for (int g = 0; g < 3; g++) begin
            sl    = cfgSl(g);
            nb    = cfgCh(g) * sl;
            start = 1'b0;
            fs    = 1'b0;
            ur    = 1'b0;
            load  = s_valid && !bfull[g];
            if (!running[g]) begin
                start = enable;
            end else begin
                t[g] = t[g] + 1;
                if (t[g] == nb * 2 * (p[g] + 1)) begin
                    if (enable) start = 1'b1;
                    else running[g] = 1'b0;
                end
            end
            if (start) begin
                prevb[g] = running[g] ? expBit(frame[g], nb - 1, (m[g] == 0) ? 1 : m[g], sl, 1'b0)
                                      : 1'b0;
                if (bfull[g]) begin
                    frame[g] = bdata[g];
                    last[g]  = bdata[g];
                    bfull[g] = 1'b0;
                end else begin
                    frame[g] = last[g];
                    ur       = 1'b1;
                end
                running[g] = 1'b1;
                t[g]       = 0;
                p[g]       = int'(prescaler);
                m[g]       = int'(mode);
                fs         = 1'b1;
            end
            if (load) begin
                bdata[g] = s_data;
                bfull[g] = 1'b1;
            end
            if (running[g]) begin
                per = 2 * (p[g] + 1);
                k   = t[g] / per;
                w   = t[g] % per;
                exp_v[g] = {(w >= p[g] + 1), expLr(k, m[g], cfgCh(g), sl),
                            expBit(frame[g], k, m[g], sl, prevb[g]), fs, ur, !bfull[g]};
            end else begin
                exp_v[g] = {5'b00000, !bfull[g]};
            end
        end
    endtask

    task automatic checkOutput();
        for (int g = 0; g < 3; g++) begin
            n_vec++;
            if (act_v[g] !== exp_v[g]) begin
                n_err++;
                $display("[TB] FAIL cfg%0d cycle %0d: got %b expected %b (sclk,lrclk,sdata,fs,ur,ready)",
                         g, cyc, act_v[g], exp_v[g]);
            end
        end
    endtask

    task automatic checkVec(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            cyc++;
            checkOutput();
        end
    endtask

    initial begin
        logic [63:0] fr_a;
        logic [63:0] fr_b;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        fr_a  = 64'h1234_8001_0F0F_A5C3;
        fr_b  = 64'h0000_0000_0000_8001;

        // Hand-computed points that pin the model's layout rules.
        checkBit("lj first bit",      expBit(fr_a, 0, 1, 16, 1'b0), 1'b1);
        checkBit("lj slot0 lsb",      expBit(fr_a, 15, 1, 16, 1'b0), 1'b1);
        checkBit("lj slot1 msb",      expBit(fr_a, 16, 1, 16, 1'b0), 1'b0);
        checkBit("lj slot1 lsb",      expBit(fr_a, 31, 1, 16, 1'b0), 1'b1);
        checkBit("i2s bit0 prev",     expBit(fr_a, 0, 0, 16, 1'b0), 1'b0);
        checkBit("i2s bit1 msb",      expBit(fr_a, 1, 0, 16, 1'b0), 1'b1);
        checkBit("i2s bit16 lsb",     expBit(fr_a, 16, 0, 16, 1'b0), 1'b1);
        checkBit("rj24 pad bit7",     expBit(fr_b, 7, 2, 24, 1'b0), 1'b0);
        checkBit("rj24 msb bit8",     expBit(fr_b, 8, 2, 24, 1'b0), 1'b1);
        checkBit("rj24 bit9",         expBit(fr_b, 9, 2, 24, 1'b0), 1'b0);
        checkBit("rj24 lsb bit23",    expBit(fr_b, 23, 2, 24, 1'b0), 1'b1);
        checkBit("lr stereo bit15",   expLr(15, 1, 2, 16), 1'b0);
        checkBit("lr stereo bit16",   expLr(16, 1, 2, 16), 1'b1);
        checkBit("lr tdm bit0",       expLr(0, 3, 4, 16), 1'b1);
        checkBit("lr tdm bit1",       expLr(1, 3, 4, 16), 1'b0);
        checkBit("lr quad bit31",     expLr(31, 1, 4, 16), 1'b0);
        checkBit("lr quad bit32",     expLr(32, 1, 4, 16), 1'b1);

        reset_n   = 1'b0;
        enable    = 1'b0;
        mode      = 2'd1;
        prescaler = 8'd0;
        s_valid   = 1'b0;
        s_data    = '0;
        modelReset();
        applyStimulus(2);
        for (int g = 0; g < 3; g++) checkVec($sformatf("reset state cfg%0d", g), act_v[g], 6'b000001);
        reset_n = 1'b1;

        s_data  = fr_a;
        s_valid = 1'b1;
        applyStimulus(1);
        s_valid = 1'b0;
        for (int g = 0; g < 3; g++) checkBit($sformatf("ready after load cfg%0d", g), act_v[g][0], 1'b0);
        enable = 1'b1;
        applyStimulus(1);
        for (int g = 0; g < 3; g++) checkVec($sformatf("first frame bit0 cfg%0d", g), act_v[g], 6'b001101);
        applyStimulus(300);

        s_data  = 64'hFFFF_0001_8000_5A5A;
        s_valid = 1'b1;
        applyStimulus(400);
        mode = 2'd0;
        applyStimulus(400);
        mode      = 2'd2;
        prescaler = 8'd1;
        applyStimulus(800);
        mode      = 2'd3;
        prescaler = 8'd3;
        applyStimulus(1200);
        s_valid = 1'b0;
        applyStimulus(1200);
        enable = 1'b0;
        applyStimulus(1200);

        mode      = 2'd0;
        prescaler = 8'd0;
        s_data    = 64'h0F0F_F0F0_A5C3_3C5A;
        s_valid   = 1'b1;
        applyStimulus(5);
        enable = 1'b1;
        applyStimulus(300);

        // Asynchronous reset in the middle of a frame, observed before the next clock edge.
        @(posedge clk);
        modelStep();
        #2 reset_n = 1'b0;
        modelReset();
        #1;
        for (int g = 0; g < 3; g++) checkVec($sformatf("async reset cfg%0d", g), act_v[g], 6'b000001);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1);
        for (int g = 0; g < 3; g++) checkBit($sformatf("restart frame_start cfg%0d", g), act_v[g][2], 1'b1);
        applyStimulus(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised successor to the fixed stereo I2S transmitter feeding the MAX9850 headphone DAC. It serialises a frame of CHANNELS samples of SAMPLE_W bits into SLOT_W-bit slots, using one of four wire formats: I2S, left-justified, right-justified or DSP/TDM. It adds a valid/ready sample interface with a one-frame holding buffer, underrun detection and frame-boundary reconfiguration. It sits between the Minimig audio mixer outputs and the board codec pins.

Parameters:
CHANNELS, 2, samples per frame (slots); must be >= 2 and even
SAMPLE_W, 16, bits per sample
SLOT_W, 16, bits per slot; must be >= SAMPLE_W
PRESC_W, 8, width of prescaler input

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  transmit enable; sampled only at frame boundary
prescaler  in  PRESC_W  half bit-period = prescaler+1 clk; sampled at frame boundary
mode  in  2  0=I2S, 1=left-just, 2=right-just, 3=DSP/TDM; sampled at frame boundary
s_valid  in  1  sample frame valid
s_ready  out  1  holding buffer empty
s_data  in  CHANNELS*SAMPLE_W  channel n at bits [n*SAMPLE_W +: SAMPLE_W]; channel 0 = slot 0
sclk  out  1  bit clock
lrclk  out  1  word select / frame sync
sdata  out  1  serial data, MSB first
frame_start  out  1  one-clk pulse on first bit period of each frame
underrun  out  1  one-clk pulse when a frame starts with empty buffer

Behaviour:
- Reset (async, immediate): sclk=0, lrclk=0, sdata=0, s_ready=1, frame_start=0, underrun=0; holding buffer empty; shift and last-frame registers zero; state IDLE.
- Handshake: buffer loads s_data on clk where s_valid&&s_ready; s_ready drops next clk. Buffer empties (s_ready=1 next clk) when transferred to shift register at frame boundary. Load and transfer on the same clk: the transfer takes the old buffer contents and the new data occupies the buffer, so s_ready stays 0.
- States: IDLE -> RUN when enable=1 (checked each clk in IDLE). RUN -> IDLE at frame boundary if enable=0. In IDLE: sclk=0, lrclk=0, sdata=0.
- Frame boundary (entry to RUN, or end of last bit of frame): latch mode and prescaler. Transfer the buffer to the shift register and to the last-frame register. If the buffer is empty, reload the last-frame register instead and pulse underrun. frame_start pulses on the same clk.
- Bit period = 2*(prescaler+1) clk. At its start sclk goes 0 and sdata/lrclk update on the same edge. sclk goes 1 after prescaler+1 clk. prescaler=0 gives clk/2.
- Frame length = CHANNELS*SLOT_W bit periods. A bit counter wraps to 0 at the end of the frame.
- Slot contents:
  - Modes 0, 1, 3: sample in the first SAMPLE_W bits of the slot, trailing bits 0.
  - Mode 2: leading SLOT_W-SAMPLE_W bits 0, LSB in the last bit of the slot.
- lrclk:
  - Modes 0-2: 0 for slots 0..CHANNELS/2-1, 1 for the remaining slots.
  - Mode 3: 1 only during bit 0 of the frame.
- Mode 0 delays the data stream by one bit period relative to mode 1. Bit 0 of a frame carries the final bit of the previous frame; that bit is 0 after reset or IDLE.
- Mid-frame changes to mode, prescaler or enable have no effect until the next boundary.

Test Plan:
- Defaults, prescaler=0, mode=1, enable=1, send L=16'hA5C3, R=16'h0F0F -> sclk period 2 clk, frame 64 clk. sdata bits 0-15 = A5C3 MSB first with lrclk=0, bits 16-31 = 0F0F with lrclk=1. frame_start every 64 clk.
- Same data, mode=0 -> lrclk edges unchanged. A5C3 MSB appears at bit 1; bit 0 of the next frame = LSB of 0F0F (1).
- SLOT_W=24, mode=2, sample 16'h8001 -> slot bits 0-7 = 0, bit 8 = 1, bit 23 = 1.
- CHANNELS=4, mode=3, prescaler=3 -> lrclk high for 8 clk at frame start only. Slots 0-3 carry channels 0-3 in order; frame = 64 bit periods = 512 clk.
- No s_valid after the first frame -> underrun pulses once per frame and the previous samples repeat. s_valid held high -> s_ready pulses once per frame, no underrun.
- reset_n low mid-frame -> all outputs 0 and s_ready=1 with no clk edge required. After release with enable=1, the first frame_start occurs on the first clk edge.
